// File: rtl/arm_mem_responder_pkg.sv
// Shared definitions for the arm_core memory responder.
// Holds the responder FSM states, the port identifiers, the latency counter
// width and the data word width used by arm_mem_responder and arm_mem_array.
package arm_mem_responder_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  typedef enum logic {
    MEM_PORT_D = 1'b0,
    MEM_PORT_I = 1'b1
  } mem_port_e;

endpackage

// File: rtl/arm_mem_array.sv
// Single-ported, byte-enabled word RAM with synchronous read and write.
// Kept as its own module so it can later be swapped for a vendor BRAM.
// Ports:
//   clk    in  clock; read and write happen on posedge when en=1
//   en     in  access enable
//   we     in  1 = write (byte-enabled), 0 = read only
//   be     in  byte enables, bit i covers wdata[8i+7:8i]
//   addr   in  word address (ADDR_W bits)
//   wdata  in  write data
//   rdata  out registered read data (old contents on a write access)
// Contents are not reset.
module arm_mem_array
  import arm_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the arm_core fetch and load/store ports.
// Both ports share one single-ported word array; each access takes LATENCY
// edges from grant to a one-cycle ready pulse, then one turnaround cycle.
// Optional feature macro: ARM_MEM_RR_ARB_EN (round-robin arbitration between
// the ports; when undefined the data port always wins a conflict).
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   inst_req      fetch request, held until inst_ready
//   inst_addr     fetch word address
//   inst          fetched word, holds until the next fetch response
//   inst_ready    one-cycle fetch response pulse
//   data_req      data request, held until data_ready
//   data_we       1 = store, 0 = load
//   data_be       store byte enables
//   mem_addr      data word address
//   mem_data_in   store data
//   mem_data_out  load data (0 on a store response), holds until next data response
//   data_ready    one-cycle data response pulse
// Address bits above ADDR_W are ignored (addresses alias modulo 2**ADDR_W).
module arm_mem_responder
  import arm_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [29:0] inst_addr,
  output logic [31:0] inst,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        data_ready
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("arm_mem_responder: LATENCY must be in 1..15");
  end

  mem_state_e            state, state_nxt;
  mem_port_e             port_q, grant_port;
  logic                  grant;
  logic [MEM_LAT_W-1:0]  cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_W-1:0]     rdata;
  logic [WORD_W-1:0]     inst_hold, data_hold;
  logic                  access;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{inst_addr[29:ADDR_W], mem_addr[29:ADDR_W]};

  // Arbitration: a grant is only possible in IDLE.
`ifdef ARM_MEM_RR_ARB_EN
  logic rr_ptr;  // 0 = data port preferred next, 1 = fetch port preferred next

  always_comb begin
    grant      = (state == MEM_IDLE) && (inst_req || data_req);
    grant_port = MEM_PORT_D;
    if (inst_req && data_req) grant_port = rr_ptr ? MEM_PORT_I : MEM_PORT_D;
    else if (inst_req)        grant_port = MEM_PORT_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= (grant_port == MEM_PORT_D);
  end
`else
  always_comb begin
    grant      = (state == MEM_IDLE) && (inst_req || data_req);
    grant_port = data_req ? MEM_PORT_D : MEM_PORT_I;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      MEM_IDLE: if (grant) state_nxt = MEM_WAIT;
      MEM_WAIT: if (cnt == '0) state_nxt = MEM_RESP;
      MEM_RESP: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // The array access (read and store commit) happens on the WAIT->RESP edge.
  assign access = (state == MEM_WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MEM_IDLE;
      port_q    <= MEM_PORT_D;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        port_q <= grant_port;
        cnt    <= MEM_LAT_W'(LATENCY - 1);
        if (grant_port == MEM_PORT_D) begin
          addr_q  <= mem_addr[ADDR_W-1:0];
          we_q    <= data_we;
          be_q    <= data_be;
          wdata_q <= mem_data_in;
        end else begin
          addr_q  <= inst_addr[ADDR_W-1:0];
          we_q    <= 1'b0;
          be_q    <= '0;
          wdata_q <= '0;
        end
      end else if (state == MEM_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == MEM_RESP) begin
        if (port_q == MEM_PORT_I) inst_hold <= rdata;
        else                      data_hold <= we_q ? '0 : rdata;
      end
    end
  end

  arm_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (access),
    .we    (we_q),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // The sync RAM output is only valid during RESP, so it is presented directly
  // in that cycle and captured into the hold registers for the cycles after.
  always_comb begin
    inst_ready   = (state == MEM_RESP) && (port_q == MEM_PORT_I);
    data_ready   = (state == MEM_RESP) && (port_q == MEM_PORT_D);
    inst         = inst_ready ? rdata : inst_hold;
    mem_data_out = data_ready ? (we_q ? '0 : rdata) : data_hold;
  end

endmodule

// File: tb/tb_arm_mem_responder.sv
// Self-checking bench for arm_mem_responder. Two instances share stimulus:
// LATENCY=2 for directed cases, LATENCY=1 for the random mixed-traffic case.
module tb_arm_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        inst_req = 1'b0;
  logic [29:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [29:0] mem_addr = '0;
  logic [31:0] mem_data_in = '0;

  logic [31:0] inst_a, inst_b, dout_a, dout_b;
  logic        irdy_a, irdy_b, drdy_a, drdy_b;
  logic [31:0] inst_x, dout_x;
  logic        irdy_x, drdy_x;
  int          cur_lat;

  always #5 clk = ~clk;

  arm_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req & ~sel), .inst_addr(inst_addr), .inst(inst_a), .inst_ready(irdy_a),
    .data_req(data_req & ~sel), .data_we(data_we), .data_be(data_be), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(dout_a), .data_ready(drdy_a)
  );

  arm_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req & sel), .inst_addr(inst_addr), .inst(inst_b), .inst_ready(irdy_b),
    .data_req(data_req & sel), .data_we(data_we), .data_be(data_be), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(dout_b), .data_ready(drdy_b)
  );

  assign inst_x  = sel ? inst_b : inst_a;
  assign dout_x  = sel ? dout_b : dout_a;
  assign irdy_x  = sel ? irdy_b : irdy_a;
  assign drdy_x  = sel ? drdy_b : drdy_a;
  assign cur_lat = sel ? 1 : 2;

  // Requests must stay high until their ready pulse.
  logic ireq_q = 1'b0, dreq_q = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      assert (!ireq_q || inst_req || irdy_x) else $error("protocol: inst_req dropped before inst_ready");
      assert (!dreq_q || data_req || drdy_x) else $error("protocol: data_req dropped before data_ready");
    end
    ireq_q <= rst ? 1'b0 : inst_req;
    dreq_q <= rst ? 1'b0 : data_req;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard and timing model
  logic [31:0] ref_mem [1024];
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  int          ecnt = 0;
  int          free_edge = 0;
  int          exp_edge_i = -1, exp_edge_d = -1;
  bit          gnt_i = 0, gnt_d = 0;
  bit          rr = 0;
  logic [31:0] last_i = '0, last_d = '0;

  // One clock: grant model at the posedge, output checks at the negedge.
  task automatic step();
    bit pi, pd, win_d;
    @(posedge clk);
    ecnt++;
    if (!rst) begin
      pi = inst_req && !gnt_i;
      pd = data_req && !gnt_d;
      if (ecnt >= free_edge && (pi || pd)) begin
`ifdef ARM_MEM_RR_ARB_EN
        win_d = pd && (!pi || !rr);
        rr = win_d;
`else
        win_d = pd;
`endif
        if (win_d) begin gnt_d = 1; exp_edge_d = ecnt + cur_lat; end
        else       begin gnt_i = 1; exp_edge_i = ecnt + cur_lat; end
        free_edge = ecnt + cur_lat + 2;
      end
    end
    @(negedge clk);
    if (irdy_x) begin
      if (q_i.size() == 0) chk("i_spurious", 32'd1, 32'd0);
      else begin
        last_i = q_i.pop_front();
        chk("inst", inst_x, last_i);
        chk("i_lat", 32'(ecnt), 32'(exp_edge_i));
      end
      inst_req = 1'b0;
      gnt_i = 0;
    end else begin
      if (gnt_i && ecnt == exp_edge_i) chk("i_ready", 32'd0, 32'd1);
      chk("i_hold", inst_x, last_i);
    end
    if (drdy_x) begin
      if (q_d.size() == 0) chk("d_spurious", 32'd1, 32'd0);
      else begin
        last_d = q_d.pop_front();
        chk("dout", dout_x, last_d);
        chk("d_lat", 32'(ecnt), 32'(exp_edge_d));
      end
      data_req = 1'b0;
      gnt_d = 0;
    end else begin
      if (gnt_d && ecnt == exp_edge_d) chk("d_ready", 32'd0, 32'd1);
      chk("d_hold", dout_x, last_d);
    end
  endtask

  // Called at a negedge with the data port idle.
  task automatic issue_d(input logic we, input logic [3:0] be, input logic [29:0] a, input logic [31:0] wd);
    logic [9:0] idx;
    idx = a[9:0];
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      q_d.push_back(32'h0);
    end else begin
      q_d.push_back(ref_mem[idx]);
    end
    data_we = we; data_be = be; mem_addr = a; mem_data_in = wd;
    data_req = 1'b1;
  endtask

  task automatic issue_i(input logic [29:0] a);
    logic [9:0] idx;
    idx = a[9:0];
    q_i.push_back(ref_mem[idx]);
    inst_addr = a;
    inst_req = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((inst_req || data_req) && n < 200) begin
      step();
      n++;
    end
    chk("idle", {30'd0, inst_req, data_req}, 32'd0);
  endtask

  // Called at a negedge; reset drops whatever is in flight.
  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    q_i.delete(); q_d.delete();
    gnt_i = 0; gnt_d = 0; free_edge = 0; rr = 0;
    last_i = '0; last_d = '0;
    #1;
    chk("rst_inst", inst_x, 32'h0);
    chk("rst_dout", dout_x, 32'h0);
    chk("rst_irdy", {31'd0, irdy_x}, 32'h0);
    chk("rst_drdy", {31'd0, drdy_x}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [19:0] hi;
    int issued;
    @(negedge clk);
    do_reset();

    // Fetch after store sees the stored word.
    issue_d(1'b1, 4'hF, 30'h10, 32'hE3A0_0001); wait_idle();
    issue_i(30'h10); wait_idle();

    // Byte-enabled merge, then a be=0 store that must not change anything.
    issue_d(1'b1, 4'hF, 30'h20, 32'hDEAD_BEEF); wait_idle();
    issue_d(1'b1, 4'h1, 30'h20, 32'h0000_00AA); wait_idle();
    issue_d(1'b0, 4'h0, 30'h20, 32'h0);         wait_idle();
    issue_d(1'b1, 4'h0, 30'h20, 32'hFFFF_FFFF); wait_idle();
    issue_d(1'b0, 4'h0, 30'h20, 32'h0);         wait_idle();

    // Simultaneous requests: ordering enforced through the latency checks.
    for (int p = 0; p < 4; p++) begin
      issue_d(1'b0, 4'h0, 30'h20, 32'h0);
      issue_i(30'h10);
      wait_idle();
    end

    // Aliasing above ADDR_W.
    issue_d(1'b1, 4'hF, 30'h400, 32'h1234_5678); wait_idle();
    issue_d(1'b0, 4'h0, 30'h000, 32'h0);         wait_idle();

    // Reset during WAIT drops an uncommitted store.
    issue_d(1'b1, 4'hF, 30'h30, 32'h0BAD_0030); wait_idle();
    issue_i(30'h10); wait_idle();
    data_we = 1'b1; data_be = 4'hF; mem_addr = 30'h30; mem_data_in = 32'hFFFF_FFFF;
    data_req = 1'b1;
    step();
    do_reset();
    for (int k = 0; k < 4; k++) step();
    issue_d(1'b0, 4'h0, 30'h30, 32'h0); wait_idle();

    // LATENCY=1 instance: random mixed traffic.
    sel = 1'b1;
    do_reset();
    for (int a = 0; a < 32; a++) begin
      hi = 20'($urandom);
      issue_d(1'b1, 4'hF, {hi, 10'(a)}, $urandom);
      wait_idle();
    end
    issued = 0;
    for (int c = 0; c < 2000 && issued < 100; c++) begin
      if (!data_req && issued < 100 && $urandom_range(0, 1) == 1) begin
        hi = 20'($urandom);
        issue_d(1'($urandom), 4'($urandom), {hi, 10'($urandom_range(0, 15))}, $urandom);
        issued++;
      end
      if (!inst_req && issued < 100 && $urandom_range(0, 1) == 1) begin
        hi = 20'($urandom);
        issue_i({hi, 10'($urandom_range(16, 31))});
        issued++;
      end
      step();
    end
    wait_idle();
    chk("issued", 32'(issued), 32'd100);
    chk("drain", 32'(q_i.size() + q_d.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
